// File: rtl/inst_queue_pkg.sv
// Shared constants for the instruction queue: instruction field positions,
// NOP encoding and the stored entry layout.
package inst_queue_pkg;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 11;
  localparam int SA_HI   = 10;
  localparam int SA_LO   = 6;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int          ENTRY_W  = 65;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
  } entry_t;

endpackage

// File: rtl/inst_queue_ram.sv
// DEPTH x ENTRY_W register array: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue (circular buffer with flush).
// Optional same-cycle bypass on empty queue: define INST_QUEUE_BYPASS_EN.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_ex,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_ex,
  output logic [5:0]       out_op,
  output logic [5:0]       out_func,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_sa,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head, tail;
  logic             empty, bypass, enq, deq;
  entry_t           wr_entry, rd_entry, head_entry;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL_CNT);
  assign deq      = !empty && !flush && out_ready;

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass = empty && !flush && in_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry consumed in the same cycle is never written.
  assign enq = in_valid && in_ready && !flush && !(bypass && out_ready);

  assign wr_entry.pc   = in_pc;
  assign wr_entry.inst = in_ex ? NOP_INST : in_inst;
  assign wr_entry.ex   = in_ex;

  inst_queue_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk   (clk),
    .we    (enq),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head_entry = rd_entry;
    out_valid  = !empty && !flush;
    if (bypass) begin
      head_entry = wr_entry;
      out_valid  = 1'b1;
    end
  end

  assign out_pc   = head_entry.pc;
  assign out_inst = head_entry.inst;
  assign out_ex   = head_entry.ex;
  assign out_op   = out_inst[OP_HI:OP_LO];
  assign out_func = out_inst[FUNC_HI:FUNC_LO];
  assign out_rs   = out_inst[RS_HI:RS_LO];
  assign out_rt   = out_inst[RT_HI:RT_LO];
  assign out_rd   = out_inst[RD_HI:RD_LO];
  assign out_sa   = out_inst[SA_HI:SA_LO];

endmodule
